// File: rtl/remote_load_latency_histogram_if.sv
// Bus bundle for the remote-load latency profiler: timestamp, issue/return events, clear and the counter read port.
// The profiled core (or a bench) drives the master modport; the profiler takes the slave modport.
interface remote_load_latency_histogram_if #(
  parameter int reg_els_p   = 32,
  parameter int num_bins_p  = 16,
  parameter int cnt_width_p = 32,
  parameter int ts_width_p  = 32
);
  localparam int reg_id_w_lp = $clog2(reg_els_p);
  localparam int bin_w_lp    = $clog2(num_bins_p);

  logic [ts_width_p-1:0]  global_ctr_i;
  logic                   enable_i;
  logic                   issue_v_i;
  logic [1:0]             issue_type_i;
  logic [reg_id_w_lp-1:0] issue_reg_id_i;
  logic                   ret_v_i;
  logic [1:0]             ret_type_i;
  logic [reg_id_w_lp-1:0] ret_reg_id_i;
  logic                   clear_i;
  logic                   rd_v_i;
  logic [1:0]             rd_type_i;
  logic [bin_w_lp-1:0]    rd_bin_i;
  logic                   rd_v_o;
  logic [cnt_width_p-1:0] rd_data_o;

  modport master (
    output global_ctr_i, enable_i,
    output issue_v_i, issue_type_i, issue_reg_id_i,
    output ret_v_i, ret_type_i, ret_reg_id_i,
    output clear_i, rd_v_i, rd_type_i, rd_bin_i,
    input  rd_v_o, rd_data_o
  );

  modport slave (
    input  global_ctr_i, enable_i,
    input  issue_v_i, issue_type_i, issue_reg_id_i,
    input  ret_v_i, ret_type_i, ret_reg_id_i,
    input  clear_i, rd_v_i, rd_type_i, rd_bin_i,
    output rd_v_o, rd_data_o
  );
endinterface

// File: rtl/remote_load_latency_histogram.sv
// Per-tile remote-load latency histogram (int / float / icache) with saturating bins and aux counters.
// Optional feature: define REMOTE_LOAD_HIST_MAX_EN to keep per-type max-latency registers (aux 2..4).
module remote_load_latency_histogram #(
  parameter int reg_els_p   = 32,
  parameter int num_bins_p  = 16,
  parameter int bin_shift_p = 2,
  parameter int cnt_width_p = 32,
  parameter int ts_width_p  = 32
) (
  input logic clk_i,
  input logic reset_n_i,
  remote_load_latency_histogram_if.slave bus
);
  localparam int reg_id_w_lp = $clog2(reg_els_p);
  localparam int bin_w_lp    = $clog2(num_bins_p);
  // int entries at [0, reg_els_p), float at [reg_els_p, 2*reg_els_p), icache last
  localparam int tbl_els_lp  = 2 * reg_els_p + 1;
  localparam int tbl_w_lp    = $clog2(tbl_els_lp);

  typedef logic [cnt_width_p-1:0] cnt_t;
  typedef logic [ts_width_p-1:0]  ts_t;
  typedef logic [tbl_w_lp-1:0]    idx_t;

  function automatic idx_t tbl_idx(input logic [1:0] t, input logic [reg_id_w_lp-1:0] r);
    case (t)
      2'd0:    return idx_t'(r);
      2'd1:    return idx_t'(reg_els_p) + idx_t'(r);
      default: return idx_t'(2 * reg_els_p);
    endcase
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + cnt_t'(1);
  endfunction

  logic pending_q  [tbl_els_lp];
  ts_t  start_ts_q [tbl_els_lp];
  cnt_t bins_q     [3][num_bins_p];
  cnt_t orphan_cnt_q;
  cnt_t overwrite_cnt_q;

  logic                issue_ok, ret_ok, ret_hit, same_entry;
  logic                orphan_inc, overwrite_inc;
  idx_t                issue_idx, ret_idx;
  ts_t                 latency, lat_bins;
  logic [bin_w_lp-1:0] bin;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    issue_ok   = bus.issue_v_i && (bus.issue_type_i != 2'd3);
    ret_ok     = bus.ret_v_i && (bus.ret_type_i != 2'd3);
    issue_idx  = tbl_idx(bus.issue_type_i, bus.issue_reg_id_i);
    ret_idx    = tbl_idx(bus.ret_type_i, bus.ret_reg_id_i);
    ret_hit    = ret_ok && pending_q[ret_idx];
    same_entry = issue_ok && ret_ok && (issue_idx == ret_idx);
    // A re-issue on the entry being returned this cycle is a fresh load, not an overwrite
    overwrite_inc = bus.enable_i && issue_ok && pending_q[issue_idx] && !same_entry;
    orphan_inc    = bus.enable_i && ret_ok && !pending_q[ret_idx];
    // Unsigned modulo subtraction handles timestamp wrap
    latency  = bus.global_ctr_i - start_ts_q[ret_idx];
    lat_bins = latency >> bin_shift_p;
    bin      = (lat_bins >= ts_t'(num_bins_p - 1)) ? bin_w_lp'(num_bins_p - 1)
                                                   : lat_bins[bin_w_lp-1:0];
  end

  // NOTE: nonblocking assignments to state; with two writes to one entry, the later one (issue) wins.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < tbl_els_lp; i++) pending_q[i] <= 1'b0;
    end else begin
      if (ret_ok)   pending_q[ret_idx]   <= 1'b0;
      if (issue_ok) pending_q[issue_idx] <= 1'b1;
    end
  end

  // NOTE: timestamp storage is not reset; it is only ever read behind its pending bit.
  always_ff @(posedge clk_i) begin
    if (issue_ok) start_ts_q[issue_idx] <= bus.global_ctr_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || bus.clear_i) begin
      for (int t = 0; t < 3; t++)
        for (int b = 0; b < num_bins_p; b++) bins_q[t][b] <= '0;
      orphan_cnt_q    <= '0;
      overwrite_cnt_q <= '0;
    end else begin
      if (ret_hit && bus.enable_i)
        bins_q[bus.ret_type_i][bin] <= sat_inc(bins_q[bus.ret_type_i][bin]);
      if (orphan_inc)    orphan_cnt_q    <= sat_inc(orphan_cnt_q);
      if (overwrite_inc) overwrite_cnt_q <= sat_inc(overwrite_cnt_q);
    end
  end

`ifdef REMOTE_LOAD_HIST_MAX_EN
  ts_t max_lat_q [3];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || bus.clear_i) begin
      for (int t = 0; t < 3; t++) max_lat_q[t] <= '0;
    end else if (ret_hit && bus.enable_i && (latency > max_lat_q[bus.ret_type_i])) begin
      max_lat_q[bus.ret_type_i] <= latency;
    end
  end
`endif

  cnt_t rd_mux;

  always_comb begin
    rd_mux = '0;
    if (bus.rd_type_i != 2'd3) begin
      rd_mux = bins_q[bus.rd_type_i][bus.rd_bin_i];
    end else begin
      case (int'(bus.rd_bin_i))
        0:       rd_mux = orphan_cnt_q;
        1:       rd_mux = overwrite_cnt_q;
`ifdef REMOTE_LOAD_HIST_MAX_EN
        2:       rd_mux = cnt_t'(max_lat_q[0]);
        3:       rd_mux = cnt_t'(max_lat_q[1]);
        4:       rd_mux = cnt_t'(max_lat_q[2]);
`endif
        default: rd_mux = '0;
      endcase
    end
  end

  // Read samples pre-update counter state, so a same-cycle increment shows on the next read
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bus.rd_v_o    <= 1'b0;
      bus.rd_data_o <= '0;
    end else begin
      bus.rd_v_o <= bus.rd_v_i;
      if (bus.rd_v_i) bus.rd_data_o <= rd_mux;
    end
  end
endmodule

// File: tb/tb_remote_load_latency_histogram.sv
// Self-checking bench for remote_load_latency_histogram: table-driven single-load vectors plus
// hand-written multi-cycle corner sequences; read expectations flow through a scoreboard queue.
module tb_remote_load_latency_histogram;
  localparam int reg_els_p   = 32;
  localparam int num_bins_p  = 16;
  localparam int bin_shift_p = 2;
  localparam int cnt_width_p = 32;
  localparam int ts_width_p  = 32;
`ifdef REMOTE_LOAD_HIST_MAX_EN
  localparam bit max_en = 1'b1;
`else
  localparam bit max_en = 1'b0;
`endif

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  remote_load_latency_histogram_if #(
    .reg_els_p(reg_els_p), .num_bins_p(num_bins_p),
    .cnt_width_p(cnt_width_p), .ts_width_p(ts_width_p)
  ) bus ();

  remote_load_latency_histogram #(
    .reg_els_p(reg_els_p), .num_bins_p(num_bins_p), .bin_shift_p(bin_shift_p),
    .cnt_width_p(cnt_width_p), .ts_width_p(ts_width_p)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [4:0]  reg_id;
    logic [31:0] issue_ts;
    logic [31:0] ret_ts;
    logic [3:0]  exp_bin;
    logic [31:0] exp_lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] r, input logic [31:0] ts);
    bus.issue_v_i = 1'b1; bus.issue_type_i = t; bus.issue_reg_id_i = r; bus.global_ctr_i = ts;
    tick();
    bus.issue_v_i = 1'b0;
  endtask

  task automatic do_ret(input logic [1:0] t, input logic [4:0] r, input logic [31:0] ts);
    bus.ret_v_i = 1'b1; bus.ret_type_i = t; bus.ret_reg_id_i = r; bus.global_ctr_i = ts;
    tick();
    bus.ret_v_i = 1'b0;
  endtask

  task automatic do_both(input logic [1:0] t, input logic [4:0] r, input logic [31:0] ts);
    bus.issue_v_i = 1'b1; bus.issue_type_i = t; bus.issue_reg_id_i = r;
    bus.ret_v_i   = 1'b1; bus.ret_type_i   = t; bus.ret_reg_id_i   = r;
    bus.global_ctr_i = ts;
    tick();
    bus.issue_v_i = 1'b0;
    bus.ret_v_i   = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  // Push the expectation, issue the read, then pop it when the registered data appears
  task automatic read_chk(input logic [1:0] t, input logic [3:0] b, input logic [31:0] exp,
                          input string name);
    exp_t e;
    bus.rd_v_i = 1'b1; bus.rd_type_i = t; bus.rd_bin_i = b;
    sb.push_back('{name, exp});
    tick();
    bus.rd_v_i = 1'b0;
    check({name, "_valid"}, {31'd0, bus.rd_v_o}, 32'd1);
    e = sb.pop_front();
    check(e.name, bus.rd_data_o, e.exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // typ, reg, issue_ts, ret_ts, bin, latency
    vecs[0] = '{2'd0, 5'd5,  32'd100,        32'd109,        4'd2,  32'd9};
    vecs[1] = '{2'd1, 5'd0,  32'hFFFF_FFFE,  32'h0000_0003,  4'd1,  32'd5};
    vecs[2] = '{2'd2, 5'd0,  32'd1000,       32'd1500,       4'd15, 32'd500};
    vecs[3] = '{2'd0, 5'd31, 32'd0,          32'd0,          4'd0,  32'd0};
    vecs[4] = '{2'd1, 5'd17, 32'd50,         32'd53,         4'd0,  32'd3};
    vecs[5] = '{2'd0, 5'd0,  32'd10,         32'd14,         4'd1,  32'd4};
    vecs[6] = '{2'd1, 5'd31, 32'd0,          32'd63,         4'd15, 32'd63};
    vecs[7] = '{2'd2, 5'd9,  32'd200,        32'd259,        4'd14, 32'd59};
    vecs[8] = '{2'd0, 5'd1,  32'd7,          32'd71,         4'd15, 32'd64};

    bus.global_ctr_i = '0; bus.enable_i = 1'b1;
    bus.issue_v_i = 1'b0; bus.issue_type_i = '0; bus.issue_reg_id_i = '0;
    bus.ret_v_i = 1'b0;   bus.ret_type_i = '0;   bus.ret_reg_id_i = '0;
    bus.clear_i = 1'b0;   bus.rd_v_i = 1'b0;     bus.rd_type_i = '0; bus.rd_bin_i = '0;

    // Reset state
    reset_n_i = 1'b0;
    repeat (3) tick();
    check("reset_rd_v", {31'd0, bus.rd_v_o}, 32'd0);
    check("reset_rd_data", bus.rd_data_o, 32'd0);
    reset_n_i = 1'b1;
    tick();
    read_chk(2'd0, 4'd0, 32'd0, "reset_int_bin0");
    read_chk(2'd3, 4'd0, 32'd0, "reset_orphan");

    // Single-load vectors
    for (int i = 0; i < 9; i++) begin
      do_clear();
      do_issue(vecs[i].typ, vecs[i].reg_id, vecs[i].issue_ts);
      do_ret(vecs[i].typ, vecs[i].reg_id, vecs[i].ret_ts);
      read_chk(vecs[i].typ, vecs[i].exp_bin, 32'd1, $sformatf("v%0d_bin", i));
      read_chk(vecs[i].typ, vecs[i].exp_bin + 4'd1, 32'd0, $sformatf("v%0d_next_bin", i));
      read_chk(2'((int'(vecs[i].typ) + 1) % 3), vecs[i].exp_bin, 32'd0,
               $sformatf("v%0d_other_type", i));
      read_chk(2'd3, 4'(2 + int'(vecs[i].typ)), max_en ? vecs[i].exp_lat : 32'd0,
               $sformatf("v%0d_max", i));
      read_chk(2'd3, 4'd0, 32'd0, $sformatf("v%0d_orphan", i));
      read_chk(2'd3, 4'd1, 32'd0, $sformatf("v%0d_overwrite", i));
    end

    // Orphan: return on int reg 7 never issued
    do_clear();
    do_ret(2'd0, 5'd7, 32'd40);
    read_chk(2'd3, 4'd0, 32'd1, "orphan_cnt");
    read_chk(2'd0, 4'd15, 32'd0, "orphan_no_bin");

    // Overwrite: latency from second issue (10 -> bin 2), not first (110 -> bin 15)
    do_clear();
    do_issue(2'd0, 5'd3, 32'd100);
    do_issue(2'd0, 5'd3, 32'd200);
    do_ret(2'd0, 5'd3, 32'd210);
    read_chk(2'd3, 4'd1, 32'd1, "overwrite_cnt");
    read_chk(2'd0, 4'd2, 32'd1, "overwrite_bin2");
    read_chk(2'd0, 4'd15, 32'd0, "overwrite_bin15");
    read_chk(2'd3, 4'd2, max_en ? 32'd10 : 32'd0, "overwrite_max_int");

    // Same-cycle issue+return on int reg 4: old ts (lat 20 -> bin 5), then new ts (lat 8 -> bin 2)
    do_clear();
    do_issue(2'd0, 5'd4, 32'd1000);
    do_both(2'd0, 5'd4, 32'd1020);
    do_ret(2'd0, 5'd4, 32'd1028);
    read_chk(2'd0, 4'd5, 32'd1, "same_cycle_bin5");
    read_chk(2'd0, 4'd2, 32'd1, "same_cycle_bin2");
    read_chk(2'd0, 4'd7, 32'd0, "same_cycle_bin7");
    read_chk(2'd3, 4'd1, 32'd0, "same_cycle_overwrite");
    read_chk(2'd3, 4'd0, 32'd0, "same_cycle_orphan");

    // Read during an increment sees the old value, the following read the new one
    do_clear();
    do_issue(2'd0, 5'd11, 32'd0);
    bus.ret_v_i = 1'b1; bus.ret_type_i = 2'd0; bus.ret_reg_id_i = 5'd11; bus.global_ctr_i = 32'd4;
    read_chk(2'd0, 4'd1, 32'd0, "read_before_update");
    bus.ret_v_i = 1'b0;
    read_chk(2'd0, 4'd1, 32'd1, "read_after_update");

    // enable_i=0: issues still tracked, nothing counted
    do_clear();
    bus.enable_i = 1'b0;
    do_issue(2'd0, 5'd6, 32'd0);
    do_issue(2'd0, 5'd6, 32'd4);
    do_ret(2'd0, 5'd6, 32'd8);
    bus.enable_i = 1'b1;
    read_chk(2'd0, 4'd1, 32'd0, "disabled_bin1");
    read_chk(2'd3, 4'd1, 32'd0, "disabled_overwrite");
    do_ret(2'd0, 5'd6, 32'd8);
    read_chk(2'd3, 4'd0, 32'd1, "disabled_pending_cleared");

    // clear_i wins over a same-cycle return
    do_clear();
    do_issue(2'd0, 5'd8, 32'd0);
    bus.clear_i = 1'b1;
    do_ret(2'd0, 5'd8, 32'd4);
    bus.clear_i = 1'b0;
    read_chk(2'd0, 4'd1, 32'd0, "clear_vs_return_bin");
    read_chk(2'd3, 4'd2, 32'd0, "clear_vs_return_max");

    // clear_i keeps pending entries; type 3 is ignored
    do_issue(2'd0, 5'd9, 32'd0);
    do_clear();
    do_ret(2'd0, 5'd9, 32'd12);
    do_issue(2'd3, 5'd2, 32'd0);
    do_ret(2'd3, 5'd2, 32'd8);
    read_chk(2'd0, 4'd3, 32'd1, "clear_keeps_pending");
    read_chk(2'd3, 4'd0, 32'd0, "type3_no_orphan");
    read_chk(2'd2, 4'd2, 32'd0, "type3_no_icache_bin");

    // Reset mid-flight drops the pending entry
    do_issue(2'd0, 5'd10, 32'd0);
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    do_ret(2'd0, 5'd10, 32'd20);
    read_chk(2'd3, 4'd0, 32'd1, "reset_midflight_orphan");
    read_chk(2'd0, 4'd5, 32'd0, "reset_midflight_bin5");

    // Aux indices past 4 read zero
    read_chk(2'd3, 4'd5, 32'd0, "aux5_zero");
    read_chk(2'd3, 4'd15, 32'd0, "aux15_zero");

    tick();
    check("rd_v_idle", {31'd0, bus.rd_v_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
